// File: rtl/spi_3x_shift_engine.sv
// ============================================================================
//  Module   : spi_3x_shift_engine
//  Purpose  : SPI master shift engine for three slaves, ACLK domain.
//             Optional `SPI_LOOPBACK_EN adds an internal MOSI->RX loopback.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_3x_shift_engine #(
    parameter int WORD_WIDTH = 8,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] tx_data,
    input  logic [1:0]            cs_sel,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic [DIV_WIDTH-1:0]  clk_div,
`ifdef SPI_LOOPBACK_EN
    input  logic                  loopback,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [WORD_WIDTH-1:0] rx_data,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic [2:0]            cs_n
);

    localparam int c_EDGE_W = $clog2(2 * WORD_WIDTH + 1);
    localparam logic [c_EDGE_W-1:0] c_LAST_EDGE = c_EDGE_W'(2 * WORD_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LEAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_TRAIL = 2'd3
    } state_t;

    state_t                r_state;
    logic [DIV_WIDTH-1:0]  r_cnt;
    logic [c_EDGE_W-1:0]   r_edge;
    logic                  r_setup;
    logic [WORD_WIDTH-1:0] r_tx;
    logic [WORD_WIDTH-1:0] r_rx;
    logic [1:0]            r_cs;
    logic                  r_cpol;
    logic                  r_cpha;
    logic [DIV_WIDTH-1:0]  r_div;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic [WORD_WIDTH-1:0] r_rx_data;
    logic                  r_sclk;
    logic                  r_mosi;
    logic [2:0]            r_cs_n;

    logic                  w_cnt_hit;
    logic [c_EDGE_W-1:0]   w_edge_nxt;
    logic                  w_sample;
    logic                  w_drive;
    logic                  w_rx_bit;

    assign w_cnt_hit  = (r_cnt == r_div);
    assign w_edge_nxt = r_edge + c_EDGE_W'(1);
    // Odd edges are leading edges; cpha picks which of leading/trailing samples.
    assign w_sample   = w_edge_nxt[0] ^ r_cpha;
    assign w_drive    = r_cpha ? w_edge_nxt[0]
                               : (!w_edge_nxt[0] && (w_edge_nxt != c_LAST_EDGE));

`ifdef SPI_LOOPBACK_EN
    logic r_loop;
    assign w_rx_bit = r_loop ? r_mosi : miso;
`else
    assign w_rx_bit = miso;
`endif

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_edge    <= '0;
            r_setup   <= 1'b0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_cs      <= 2'd0;
            r_cpol    <= 1'b0;
            r_cpha    <= 1'b0;
            r_div     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_rx_data <= '0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_cs_n    <= 3'b111;
`ifdef SPI_LOOPBACK_EN
            r_loop    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                    r_sclk <= cpol;
                    r_cs_n <= 3'b111;
                    if (start) begin
                        if (cs_sel == 2'd3) begin
                            r_err <= 1'b1;
                        end else begin
                            r_tx    <= tx_data;
                            r_cs    <= cs_sel;
                            r_cpol  <= cpol;
                            r_cpha  <= cpha;
                            r_div   <= clk_div;
`ifdef SPI_LOOPBACK_EN
                            r_loop  <= loopback;
`endif
                            r_cnt   <= '0;
                            r_edge  <= '0;
                            r_setup <= 1'b1;
                            r_busy  <= 1'b1;
                            r_state <= S_LEAD;
                        end
                    end
                end
                S_LEAD: begin
                    // Setup cycle asserts CS and presents the MSB before H is counted.
                    if (r_setup) begin
                        r_setup <= 1'b0;
                        r_cs_n  <= ~(3'b001 << r_cs);
                        if (!r_cpha) begin
                            r_mosi <= r_tx[WORD_WIDTH-1];
                        end
                    end else if (w_cnt_hit) begin
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + DIV_WIDTH'(1);
                    end
                end
                S_SHIFT: begin
                    if (w_cnt_hit) begin
                        r_cnt  <= '0;
                        r_edge <= w_edge_nxt;
                        r_sclk <= ~r_sclk;
                        if (w_sample) begin
                            r_rx <= {r_rx[WORD_WIDTH-2:0], w_rx_bit};
                        end
                        if (w_drive) begin
                            r_mosi <= r_cpha ? r_tx[WORD_WIDTH-1] : r_tx[WORD_WIDTH-2];
                            r_tx   <= {r_tx[WORD_WIDTH-2:0], 1'b0};
                        end
                        if (w_edge_nxt == c_LAST_EDGE) begin
                            r_state <= S_TRAIL;
                        end
                    end else begin
                        r_cnt <= r_cnt + DIV_WIDTH'(1);
                    end
                end
                S_TRAIL: begin
                    if (w_cnt_hit) begin
                        r_cnt     <= '0;
                        r_cs_n    <= 3'b111;
                        r_rx_data <= r_rx;
                        r_done    <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + DIV_WIDTH'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;
    assign rx_data = r_rx_data;
    assign sclk    = r_sclk;
    assign mosi    = r_mosi;
    assign cs_n    = r_cs_n;

endmodule

`default_nettype wire

// File: tb/tb_spi_3x_shift_engine.sv
// ============================================================================
//  Module   : tb_spi_3x_shift_engine
//  Purpose  : Self-checking bench for spi_3x_shift_engine with an SPI slave model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spi_3x_shift_engine;

    localparam int W = 8;

    logic         ACLK = 1'b0;
    logic         ARESETN;
    logic         start;
    logic [W-1:0] tx_data;
    logic [1:0]   cs_sel;
    logic         cpol;
    logic         cpha;
    logic [7:0]   clk_div;
    logic         loopback;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] rx_data;
    logic         sclk;
    logic         mosi;
    logic         miso;
    logic [2:0]   cs_n;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    spi_3x_shift_engine #(.WORD_WIDTH(W), .DIV_WIDTH(8)) dut (
        .ACLK     (ACLK),
        .ARESETN  (ARESETN),
        .start    (start),
        .tx_data  (tx_data),
        .cs_sel   (cs_sel),
        .cpol     (cpol),
        .cpha     (cpha),
        .clk_div  (clk_div),
`ifdef SPI_LOOPBACK_EN
        .loopback (loopback),
`endif
        .busy     (busy),
        .done     (done),
        .err      (err),
        .rx_data  (rx_data),
        .sclk     (sclk),
        .mosi     (mosi),
        .miso     (miso),
        .cs_n     (cs_n)
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    // Behavioural SPI slave: shifts slv_word out MSB first and captures MOSI.
    logic [W-1:0] slv_word = '0;
    logic [W-1:0] cap      = '0;
    logic         m_cpol   = 1'b0;
    logic         m_cpha   = 1'b0;
    logic [2:0]   exp_cs   = 3'b111;
    logic         prev_sclk = 1'b0;
    bit           in_xfer  = 1'b0;
    bit           cs_bad   = 1'b0;
    int           out_idx  = 0;
    int           edges    = 0;
    int           done_count = 0;

    function automatic logic slv_bit(input int idx);
        return (idx < W) ? slv_word[W-1-idx] : 1'b0;
    endfunction

    always @(negedge ACLK) begin
        if (cs_n === 3'b111) begin
            in_xfer = 1'b0;
        end else begin
            if (!in_xfer) begin
                in_xfer = 1'b1;
                out_idx = 0;
                edges   = 0;
                cap     = '0;
                if (!m_cpha) miso = slv_bit(0);
            end
            if (cs_n !== exp_cs) cs_bad = 1'b1;
            if (sclk !== prev_sclk) begin
                edges++;
                if ((sclk !== m_cpol) == !m_cpha) begin
                    cap = {cap[W-2:0], mosi};
                end else if (m_cpha) begin
                    miso = slv_bit(out_idx);
                    out_idx++;
                end else begin
                    out_idx++;
                    miso = slv_bit(out_idx);
                end
            end
        end
        if (done === 1'b1) done_count++;
        prev_sclk = sclk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_xfer(input logic [W-1:0] tx, input logic [1:0] cs, input logic cp,
                            input logic ch, input logic [7:0] div, input logic [W-1:0] sw,
                            input logic lb, input bit disturb);
        int t_acc;
        int lat;
        int dc0;
        logic [W-1:0] exp_rx;
        lat    = 1 + (int'(div) + 1) * (2 * W + 2);
        exp_rx = lb ? tx : sw;
        @(negedge ACLK);
        tx_data = tx; cs_sel = cs; cpol = cp; cpha = ch; clk_div = div; loopback = lb;
        slv_word = sw; m_cpol = cp; m_cpha = ch; exp_cs = ~(3'b001 << cs); cs_bad = 1'b0;
        dc0 = done_count;
        start = 1'b1;
        @(posedge ACLK); #1;
        t_acc = cyc;
        start = 1'b0;
        check("busy_rise", busy, 1);
        if (disturb) begin
            @(negedge ACLK);
            start = 1'b1; tx_data = ~tx; cs_sel = (cs == 2'd2) ? 2'd0 : cs + 2'd1;
            cpha = ~ch; clk_div = div + 8'd3;
            repeat (3) @(negedge ACLK);
            start = 1'b0; tx_data = tx; cs_sel = cs; cpha = ch; clk_div = div;
        end
        while (done !== 1'b1 && (cyc - t_acc) < lat + 50) begin
            @(posedge ACLK); #1;
        end
        check("latency", cyc - t_acc, lat);
        check("rx_data", rx_data, exp_rx);
        check("busy_at_done", busy, 1);
        check("mosi_word", cap, tx);
        check("sclk_edges", edges, 2 * W);
        check("cs_onehot", cs_bad, 0);
        @(posedge ACLK); #1;
        check("busy_fall", busy, 0);
        check("done_pulse", done, 0);
        check("cs_release", cs_n, 3'b111);
        check("sclk_idle", sclk, cp);
        check("done_count", done_count - dc0, 1);
    endtask

    initial begin
        int dc0;
        logic s0;
        bit   reached;
        ARESETN = 1'b0; start = 1'b0; tx_data = '0; cs_sel = 2'd0; cpol = 1'b0;
        cpha = 1'b0; clk_div = 8'd0; loopback = 1'b0; miso = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_rx", rx_data, 0);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_cs", cs_n, 3'b111);
        @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);

        run_xfer(8'hA5, 2'd1, 1'b0, 1'b0, 8'd1, 8'h3C, 1'b0, 1'b0);
        run_xfer(8'h81, 2'd2, 1'b1, 1'b1, 8'd0, 8'hFF, 1'b0, 1'b0);

        // Illegal chip select is rejected with a single err pulse.
        @(negedge ACLK);
        dc0 = done_count; s0 = sclk;
        cs_sel = 2'd3; start = 1'b1;
        @(posedge ACLK); #1;
        start = 1'b0;
        check("err_pulse", err, 1);
        check("err_busy", busy, 0);
        check("err_cs", cs_n, 3'b111);
        check("err_sclk", sclk, s0);
        @(posedge ACLK); #1;
        check("err_clear", err, 0);
        repeat (6) @(posedge ACLK);
        #1;
        check("err_no_done", done_count - dc0, 0);
        check("err_no_busy", busy, 0);

        run_xfer($urandom, 2'd0, 1'b0, 1'b1, 8'd2, $urandom, 1'b0, 1'b1);

        for (int i = 0; i < 6; i++) begin
            run_xfer($urandom, 2'($urandom_range(0, 2)), 1'($urandom), 1'($urandom),
                     8'($urandom_range(0, 3)), $urandom, 1'b0, 1'b0);
        end
        run_xfer($urandom, 2'd1, 1'b1, 1'b0, 8'hFF, $urandom, 1'b0, 1'b0);

        // Asynchronous reset in the middle of SHIFT.
        @(negedge ACLK);
        dc0 = done_count;
        tx_data = $urandom; cs_sel = 2'd0; cpol = 1'b0; cpha = 1'b0; clk_div = 8'd1;
        slv_word = $urandom; m_cpol = 1'b0; m_cpha = 1'b0; exp_cs = 3'b110;
        start = 1'b1;
        @(posedge ACLK); #1;
        start = 1'b0;
        reached = 1'b0;
        for (int k = 0; k < 200 && !reached; k++) begin
            @(negedge ACLK);
            if (edges == 5 && cs_n !== 3'b111) reached = 1'b1;
        end
        check("rst_edge5_reached", reached, 1);
        #2 ARESETN = 1'b0;
        #1;
        check("mid_rst_cs", cs_n, 3'b111);
        check("mid_rst_sclk", sclk, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rx", rx_data, 0);
        check("mid_rst_done", done, 0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (3) @(negedge ACLK);
        check("mid_rst_no_done", done_count - dc0, 0);
        run_xfer($urandom, 2'd2, 1'b0, 1'b0, 8'd1, $urandom, 1'b0, 1'b0);

`ifdef SPI_LOOPBACK_EN
        for (int m = 0; m < 4; m++) begin
            run_xfer(8'h5A, 2'($urandom_range(0, 2)), 1'(m >> 1), 1'(m), 8'd1, 8'h00, 1'b1, 1'b0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/spi_3x_shift_engine.md
Name: spi_3x_shift_engine

Overview:
- SPI master shift engine directly downstream of the AXI4-Lite register slave in the 3-slave SPI master IP.
- Takes one transfer command (TX word, chip-select index, mode, clock divider) from the register file.
- Drives SCLK/MOSI/CS_n for one of three slaves, samples MISO, and returns the RX word with a done pulse.
- Runs in the ACLK domain; the register file must not issue a new command until busy deasserts.

Parameters:
- WORD_WIDTH, 8, bits per transfer (legal 4..32)
- DIV_WIDTH, 8, width of clk_div

Ports:
- ACLK  in  1  system clock
- ARESETN  in  1  asynchronous active-low reset
- start  in  1  transfer request; sampled only in IDLE
- tx_data  in  WORD_WIDTH  word to transmit, MSB first
- cs_sel  in  2  slave index 0..2; 3 is illegal
- cpol  in  1  SCLK idle level
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
- clk_div  in  DIV_WIDTH  half-period H = clk_div+1 ACLK cycles
- busy  out  1  high from the cycle after an accepted start through the done cycle
- done  out  1  one-cycle pulse at end of transfer
- err  out  1  one-cycle pulse when start is rejected for cs_sel=3
- rx_data  out  WORD_WIDTH  last received word, held until the next done
- sclk  out  1  SPI clock
- mosi  out  1  SPI data out
- miso  in  1  SPI data in
- cs_n  out  3  active-low chip selects, one-hot-low

Behaviour:
- Clock and reset: one clock, ACLK. ARESETN is asynchronous and active-low.
- Reset values: busy=0, done=0, err=0, rx_data=0, sclk=0, mosi=0, cs_n=3'b111, FSM=IDLE, counters=0.
- Reset mid-transfer: all outputs return to reset values immediately. No done pulse is issued. rx_data is cleared.
- FSM states: IDLE, LEAD, SHIFT, TRAIL.
- IDLE:
  - sclk is the registered cpol; cs_n=111.
  - start with cs_sel<3: latch tx_data, cs_sel, cpol, cpha and clk_div; go to LEAD.
  - start with cs_sel=3: err=1 for one cycle; stay in IDLE.
  - start while not in IDLE is ignored. Input changes after latching have no effect.
- LEAD:
  - Lasts H cycles. cs_n[cs_sel]=0.
  - cpha=0: mosi is driven with the MSB on entry.
  - Go to SHIFT.
- SHIFT:
  - 2*WORD_WIDTH SCLK edges, each H cycles apart. sclk toggles at each edge and starts at cpol.
  - cpha=0: sample miso on odd edges (leading); shift mosi on even edges, except the final edge.
  - cpha=1: shift mosi on odd edges (the first drives the MSB); sample on even edges.
  - After the last edge go to TRAIL.
- TRAIL:
  - Lasts H cycles. sclk=cpol, CS still asserted.
  - On exit: cs_n=111, rx_data=received word, done=1; return to IDLE.
- RX shift: MSB first; the first sampled bit lands in rx_data[WORD_WIDTH-1].
- Latency: done asserts exactly 1+H*(2*WORD_WIDTH+2) cycles after the ACLK edge that accepted start.
- busy timing: busy=1 in the cycle done=1 and falls the following cycle. A new start is accepted in the cycle after done.
- clk_div=0 gives H=1, i.e. SCLK=ACLK/2. clk_div=all-ones gives H=2^DIV_WIDTH; the counter must not overflow.
- Unselected cs_n bits stay 1 at all times.

Optional Feature:
- Macro: SPI_LOOPBACK_EN.
- Defined:
  - Adds input port loopback (1 bit).
  - When the loopback value latched at start is 1, the sampler uses internal mosi instead of miso; external pins toggle normally.
  - rx_data equals tx_data for every mode.
- Undefined: port absent; the sampler always uses miso.

Test Plan:
- Mode 0, WORD_WIDTH=8, clk_div=1, cs_sel=1, tx=0xA5, miso driven by a model returning 0x3C -> cs_n=101 during the transfer; mosi shows 1,0,1,0,0,1,0,1 on rising edges; done exactly 37 cycles after start; rx_data=0x3C.
- Mode 3 (cpol=1, cpha=1), clk_div=0, cs_sel=2, tx=0x81, model returns 0xFF -> sclk idles high; 16 edges at ACLK/2; done at 19 cycles; rx_data=0xFF; cs_n=011 during the transfer.
- start with cs_sel=3 -> err pulse for one cycle; busy, cs_n and sclk unchanged; no done.
- Second start and changed tx_data while busy -> ignored; transmitted bits match the first word; exactly one done.
- ARESETN pulled low at SHIFT edge 5, then released -> cs_n=111, sclk=0, busy=0, rx_data=0 immediately; no done; the next start completes normally.
- SPI_LOOPBACK_EN defined, loopback=1, tx=0x5A, miso held 0 -> rx_data=0x5A in all four modes.
